// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_state_e  : fetch FSM states (IDLE, REQ, WAIT, DROP)
//   fetch_entry_t  : one buffered fetch result {pc, inst, fault}
//   RESET_PC_DEFAULT, PC_STEP_DEFAULT, NOP_INST, FIFO sizing
package fetch_unit_pkg;

   localparam int unsigned XLEN             = 32;
   localparam int unsigned FIFO_DEPTH       = 2;
   localparam int unsigned CNT_W            = 2;
   localparam int unsigned PC_STEP_DEFAULT  = 4;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h3000_0000;
   localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
   localparam logic [XLEN-1:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DROP = 2'd3
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
      logic            fault;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_buf.sv
// fetch_buf: 2-entry synchronous FIFO of fetch entries.
//   clock, reset  : clock, synchronous active-high reset
//   clear         : drop all entries (wins over push/pop)
//   push, push_entry : write one entry
//   pop           : retire head entry
//   count         : number of valid entries (0..2)
//   head          : entry at the read pointer (registered storage)
module fetch_buf
   import fetch_unit_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             push,
   input  fetch_entry_t     push_entry,
   input  logic             pop,
   output logic [CNT_W-1:0] count,
   output fetch_entry_t     head
);

   fetch_entry_t mem [FIFO_DEPTH];
   logic         rd_ptr;
   logic         wr_ptr;
   logic         do_push;
   logic         do_pop;

   // Push into a full FIFO is only legal when the head leaves the same cycle.
   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CNT_W'(FIFO_DEPTH)) || do_pop);

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (clear) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_entry;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding decode.
// Holds the PC, issues single-outstanding word reads, buffers up to two
// responses and presents {pc, inst} with a valid/ready handshake.
// Ports:
//   clock, reset                 : clock, synchronous active-high reset
//   imem_req_valid/ready/addr    : instruction memory read request
//   imem_rsp_valid/data/err      : instruction memory response (no back-pressure)
//   ifu_pc, inst, inst_valid     : presented entry to decode
//   idu_ready, block             : decode accept / downstream stall
//   fetch_fault                  : presented entry carries a bus error
//   redirect_valid, redirect_pc  : load new PC (low two bits forced to 0)
//   clear_pipeline               : flush buffered instructions
// Build option FETCH_PERF_COUNTERS_EN adds perf_fetch_cnt, perf_drop_cnt,
// perf_stall_cnt outputs.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned     PC_STEP  = PC_STEP_DEFAULT
)(
   input  logic            clock,
   input  logic            reset,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            imem_rsp_err,
   output logic [XLEN-1:0] ifu_pc,
   output logic [XLEN-1:0] inst,
   output logic            inst_valid,
   input  logic            idu_ready,
   input  logic            block,
   output logic            fetch_fault,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            clear_pipeline
`ifdef FETCH_PERF_COUNTERS_EN
   ,
   output logic [31:0]     perf_fetch_cnt,
   output logic [31:0]     perf_drop_cnt,
   output logic [31:0]     perf_stall_cnt
`endif
);

   fetch_state_e     state;
   fetch_state_e     state_n;
   logic [XLEN-1:0]  pc;
   logic [XLEN-1:0]  pc_n;
   logic [XLEN-1:0]  req_pc;
   logic [CNT_W-1:0] fifo_count;
   fetch_entry_t     head;
   fetch_entry_t     push_entry;
   logic             flush;
   logic             outstanding;
   logic             req_fire;
   logic             rsp_take;
   logic             push;
   logic             pop;
   logic             credit_after_rsp;

   assign flush       = redirect_valid | clear_pipeline;
   assign outstanding = (state == WAIT) || (state == DROP);
   assign req_fire    = (state == REQ) && imem_req_ready;
   assign rsp_take    = (state == WAIT) && imem_rsp_valid;
   assign inst_valid  = (fifo_count != '0);
   assign pop         = inst_valid && idu_ready && !block && !flush;
   assign push        = rsp_take && !flush;

   // Faulting responses are stored as a nop so the FIFO head is presentable as-is.
   assign push_entry = '{pc:    req_pc,
                         inst:  imem_rsp_err ? NOP_INST : imem_rsp_data,
                         fault: imem_rsp_err};

   // After the pending response lands, outstanding drops to 0 and count becomes count+1-pop.
   assign credit_after_rsp = (fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop);

   fetch_buf u_buf (
      .clock      (clock),
      .reset      (reset),
      .clear      (flush),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .count      (fifo_count),
      .head       (head)
   );

   // State, PC and request-PC registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= IDLE;
         pc     <= RESET_PC;
         req_pc <= '0;
      end else begin
         state <= state_n;
         pc    <= pc_n;
         if (req_fire) begin
            req_pc <= pc;
         end
      end
   end

   // Next-state and next-PC.
   always_comb begin
      state_n = state;
      pc_n    = pc;
      case (state)
         IDLE: begin
            if (fifo_count < CNT_W'(FIFO_DEPTH)) begin
               state_n = REQ;
            end
         end
         REQ: begin
            if (imem_req_ready) begin
               state_n = WAIT;
               pc_n    = pc + XLEN'(PC_STEP);
            end
         end
         WAIT: begin
            if (imem_rsp_valid) begin
               state_n = credit_after_rsp ? REQ : IDLE;
            end
         end
         DROP: begin
            if (imem_rsp_valid) begin
               state_n = REQ;
            end
         end
         default: state_n = IDLE;
      endcase
      // A response arriving in the flush cycle completes the transaction, so
      // only a still-pending or just-issued request needs the DROP state.
      if (flush) begin
         pc_n    = redirect_valid ? (redirect_pc & PC_ALIGN_MASK) : pc;
         state_n = (req_fire || (outstanding && !imem_rsp_valid)) ? DROP : REQ;
      end
   end

   assign imem_req_valid = (state == REQ);
   assign imem_req_addr  = pc;

   assign ifu_pc      = inst_valid ? head.pc   : '0;
   assign inst        = inst_valid ? head.inst : '0;
   assign fetch_fault = inst_valid && head.fault;

`ifdef FETCH_PERF_COUNTERS_EN
   // Event counters; untouched by clear_pipeline, wrap naturally.
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_fetch_cnt <= '0;
         perf_drop_cnt  <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (push) begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         end
         if ((state == DROP) && imem_rsp_valid) begin
            perf_drop_cnt <= perf_drop_cnt + 32'd1;
         end
         if (inst_valid && (!idu_ready || block)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: memory model answering addr ^ 32'hA5A5_0000 with
// programmable latency and error address, and a scoreboard of expected
// {pc, inst, fault} entries checked by a monitor on every consumption.
`timescale 1ns/1ps
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam logic [31:0] KEY = 32'hA5A5_0000;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data  = '0;
   logic        imem_rsp_err   = 1'b0;
   logic [31:0] ifu_pc;
   logic [31:0] inst;
   logic        inst_valid;
   logic        idu_ready = 1'b0;
   logic        block = 1'b0;
   logic        fetch_fault;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        clear_pipeline = 1'b0;
`ifdef FETCH_PERF_COUNTERS_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_drop_cnt;
   logic [31:0] perf_stall_cnt;
`endif

   always #5 clock = ~clock;

   fetch_unit dut (
      .clock          (clock),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .imem_rsp_err   (imem_rsp_err),
      .ifu_pc         (ifu_pc),
      .inst           (inst),
      .inst_valid     (inst_valid),
      .idu_ready      (idu_ready),
      .block          (block),
      .fetch_fault    (fetch_fault),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .clear_pipeline (clear_pipeline)
`ifdef FETCH_PERF_COUNTERS_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_drop_cnt  (perf_drop_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   int checks   = 0;
   int failures = 0;
   int consumed = 0;
   fetch_entry_t sb_q[$];
   fetch_entry_t exp_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic sb_push(input logic [31:0] pc, input logic fault);
      fetch_entry_t e;
      e.pc    = pc;
      e.inst  = fault ? 32'h0000_0013 : (pc ^ KEY);
      e.fault = fault;
      sb_q.push_back(e);
   endtask

   // Memory model: one response per accepted request after rsp_lat cycles.
   int          rsp_lat  = 1;
   logic        err_en   = 1'b0;
   logic [31:0] err_addr = '0;
   int          mem_cnt  = 0;
   logic [31:0] mem_addr = '0;

   always @(posedge clock) begin
      imem_rsp_valid <= 1'b0;
      imem_rsp_err   <= 1'b0;
      if (reset) begin
         mem_cnt <= 0;
      end else if (imem_req_valid && imem_req_ready) begin
         mem_addr <= imem_req_addr;
         if (rsp_lat <= 1) begin
            imem_rsp_valid <= 1'b1;
            imem_rsp_data  <= imem_req_addr ^ KEY;
            imem_rsp_err   <= err_en && (imem_req_addr == err_addr);
         end else begin
            mem_cnt <= rsp_lat - 1;
         end
      end else if (mem_cnt != 0) begin
         mem_cnt <= mem_cnt - 1;
         if (mem_cnt == 1) begin
            imem_rsp_valid <= 1'b1;
            imem_rsp_data  <= mem_addr ^ KEY;
            imem_rsp_err   <= err_en && (mem_addr == err_addr);
         end
      end
   end

   // Monitor: every entry decode takes must match the scoreboard head.
   always @(negedge clock) begin
      if (!reset && inst_valid && idu_ready && !block && !redirect_valid && !clear_pipeline) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_entry actual_pc=%h required=none", ifu_pc);
         end else begin
            exp_e = sb_q.pop_front();
            check("entry_pc", ifu_pc, exp_e.pc);
            check("entry_inst", inst, exp_e.inst);
            check("entry_fault", 32'(fetch_fault), 32'(exp_e.fault));
         end
         consumed++;
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_consumed(input int n, input string name);
      int t = 0;
      while (consumed < n && t < 300) begin
         step();
         t++;
      end
      check(name, 32'(consumed), 32'(n));
   endtask

   task automatic wait_req_hs(input logic [31:0] addr, input string name);
      int t = 0;
      logic seen = 1'b0;
      while (!seen && t < 100) begin
         @(negedge clock);
         seen = imem_req_valid && imem_req_ready;
         t++;
      end
      check({name, "_seen"}, 32'(seen), 32'd1);
      check(name, imem_req_addr, addr);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int   lat;
      logic req_seen;
      repeat (3) step();

      // Reset values
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_inst_valid", 32'(inst_valid), 32'd0);
      check("rst_fetch_fault", 32'(fetch_fault), 32'd0);
      check("rst_inst", inst, 32'd0);
      check("rst_ifu_pc", ifu_pc, 32'd0);
`ifdef FETCH_PERF_COUNTERS_EN
      check("rst_perf_fetch", perf_fetch_cnt, 32'd0);
      check("rst_perf_drop", perf_drop_cnt, 32'd0);
      check("rst_perf_stall", perf_stall_cnt, 32'd0);
`endif

      // 1: sequential fetch from RESET_PC
      sb_push(32'h3000_0000, 1'b0);
      sb_push(32'h3000_0004, 1'b0);
      sb_push(32'h3000_0008, 1'b0);
      idu_ready = 1'b1;
      reset     = 1'b0;
      lat       = 0;
      req_seen  = 1'b0;
      while (!inst_valid && lat < 20) begin
         step();
         lat++;
         if (imem_req_valid && !req_seen) begin
            req_seen = 1'b1;
            check("first_addr", imem_req_addr, 32'h3000_0000);
         end
      end
      check("first_req_seen", 32'(req_seen), 32'd1);
      check("first_latency_ge3", 32'(lat >= 3), 32'd1);
      wait_consumed(3, "p1_consumed");
      idu_ready = 1'b0;

      // 2: decode stall fills the FIFO, then requests stop
      for (int i = 0; i < 10; i++) begin
         step();
         if (i >= 6) begin
            check("stall_no_req", 32'(imem_req_valid), 32'd0);
            check("stall_head_valid", 32'(inst_valid), 32'd1);
         end
      end
      sb_push(32'h3000_000C, 1'b0);
      sb_push(32'h3000_0010, 1'b0);
      sb_push(32'h3000_0014, 1'b0);
      sb_push(32'h3000_0018, 1'b0);
      idu_ready = 1'b1;
      wait_consumed(7, "p2_consumed");
      idu_ready = 1'b0;

      // 3: redirect while a 3-cycle response is outstanding
      repeat (8) step();
      rsp_lat        = 3;
      clear_pipeline = 1'b1;
      step();
      clear_pipeline = 1'b0;
      lat = 0;
      while (mem_cnt == 0 && lat < 20) begin
         step();
         lat++;
      end
      check("p3_outstanding", 32'(mem_cnt != 0), 32'd1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0102;
      step();
      redirect_valid = 1'b0;
      check("p3_fifo_cleared", 32'(inst_valid), 32'd0);
      check("p3_no_req_in_drop", 32'(imem_req_valid), 32'd0);
      sb_push(32'h8000_0100, 1'b0);
      sb_push(32'h8000_0104, 1'b0);
      idu_ready = 1'b1;
      wait_req_hs(32'h8000_0100, "p3_redirect_addr");
      wait_consumed(9, "p3_consumed");
      idu_ready = 1'b0;

      // 4: request held off, clear_pipeline mid-wait withdraws and reissues
      repeat (12) step();
      rsp_lat        = 1;
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h4000_0000;
      step();
      redirect_valid = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         check("p4_no_entry", 32'(inst_valid), 32'd0);
         check("p4_req_valid", 32'(imem_req_valid), 32'd1);
         check("p4_addr_stable", imem_req_addr, 32'h4000_0000);
         clear_pipeline = (c == 2);
         step();
      end
      clear_pipeline = 1'b0;
      imem_req_ready = 1'b1;
      sb_push(32'h4000_0000, 1'b0);
      sb_push(32'h4000_0004, 1'b0);
      idu_ready = 1'b1;
      wait_consumed(11, "p4_consumed");
      idu_ready = 1'b0;

      // 5: bus error on 0x3000_0004 presents a faulting nop
      repeat (8) step();
      err_en         = 1'b1;
      err_addr       = 32'h3000_0004;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h3000_0000;
      step();
      redirect_valid = 1'b0;
      sb_push(32'h3000_0000, 1'b0);
      sb_push(32'h3000_0004, 1'b1);
      sb_push(32'h3000_0008, 1'b0);
      idu_ready = 1'b1;
      wait_consumed(14, "p5_consumed");
      idu_ready = 1'b0;

      // 6: PC wraps from 0xFFFF_FFFC to 0; block suppresses consumption
      repeat (8) step();
      err_en         = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      sb_push(32'hFFFF_FFFC, 1'b0);
      sb_push(32'h0000_0000, 1'b0);
      wait_req_hs(32'hFFFF_FFFC, "p6_addr_top");
      wait_req_hs(32'h0000_0000, "p6_addr_wrap");
      repeat (4) step();
      block     = 1'b1;
      idu_ready = 1'b1;
      repeat (4) step();
      check("block_hold_valid", 32'(inst_valid), 32'd1);
      check("block_no_consume", 32'(consumed), 32'd14);
      block = 1'b0;
      wait_consumed(16, "p6_consumed");
      idu_ready = 1'b0;

      repeat (5) step();
      check("sb_empty", 32'(sb_q.size()), 32'd0);
`ifdef FETCH_PERF_COUNTERS_EN
      check("perf_drop_total", perf_drop_cnt, 32'd1);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decode stage.
- Holds the PC and issues word reads on a single-outstanding instruction-memory request/response channel.
- Buffers returned instructions in a 2-entry FIFO and presents {pc, inst} to decode with a valid/ready handshake.
- Accepts redirects (jump, branch, trap, mret, fence.i) and pipeline flushes; discards any in-flight response that became stale.

Parameters:
- RESET_PC, 32'h3000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- imem_req_valid  out  1  read request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  read data valid; memory never back-pressures.
- imem_rsp_data  in  32  instruction word.
- imem_rsp_err  in  1  bus error on this response.
- ifu_pc  out  32  PC of presented instruction.
- inst  out  32  presented instruction word.
- inst_valid  out  1  FIFO head valid.
- idu_ready  in  1  decode can accept.
- block  in  1  downstream stall; no consumption this cycle.
- fetch_fault  out  1  presented entry carries a bus error.
- redirect_valid  in  1  load new PC.
- redirect_pc  in  32  target PC; bits [1:0] are ignored and forced to 0.
- clear_pipeline  in  1  flush buffered instructions.

Behaviour:
- Reset values:
  - pc=RESET_PC; FIFO empty; outstanding=0; drop=0.
  - imem_req_valid=0, inst_valid=0, fetch_fault=0, inst=0, ifu_pc=0.
  - Reset mid-transaction abandons the transaction. A response arriving later is ignored because drop=0 and outstanding=0 (unsolicited responses are always discarded).
- State machine, states IDLE, REQ, WAIT, DROP:
  - IDLE -> REQ when credit is available, i.e. fifo_count + outstanding < 2.
  - REQ: imem_req_valid=1, imem_req_addr=pc. Address and valid stay stable until imem_req_ready. On handshake: outstanding=1, pc<=pc+PC_STEP, go to WAIT.
  - WAIT: on imem_rsp_valid, push {pc_of_req, data, err}, outstanding=0, go to REQ if credit remains, else IDLE.
  - DROP: a redirect or flush happened while outstanding=1. Wait for the response, discard it, go to REQ.
- Redirect or flush:
  - FIFO cleared the same cycle.
  - pc<=redirect_pc, or pc unchanged if only clear_pipeline is asserted.
  - State goes to DROP if outstanding or if the request handshakes this cycle; otherwise REQ.
  - A request un-handshaked in REQ is withdrawn; the next cycle drives the new address. This is the only permitted address change while valid.
- Priority: reset > redirect/clear > response push > consume.
- Consume when inst_valid & idu_ready & !block. Push and pop in the same cycle are allowed at count 1 or 2.
- Output timing: outputs are driven from the FIFO head (registered storage, no combinational path from imem_rsp_data). First instruction after reset is visible no earlier than 3 cycles after reset deasserts with zero-wait memory.
- Throughput: with zero-wait memory and decode always ready, one instruction per 2 cycles (single outstanding).
- Bus error:
  - Entry is presented with fetch_fault=1 and inst=32'h0000_0013 (nop).
  - Fetching continues sequentially; the downstream trap path issues the redirect.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.

Optional Feature:
- Macro FETCH_PERF_COUNTERS_EN.
- Defined: adds outputs perf_fetch_cnt (32, responses pushed), perf_drop_cnt (32, responses discarded in DROP) and perf_stall_cnt (32, cycles with inst_valid & (!idu_ready | block)). All counters:
  - reset to 0
  - wrap modulo 2^32
  - are unaffected by clear_pipeline
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package:
  - state enum {IDLE, REQ, WAIT, DROP}
  - RESET_PC default
  - NOP_INST = 32'h0000_0013
  - fetch entry struct {pc[31:0], inst[31:0], fault}
- One sub-module, fetch_buf: a 2-entry synchronous FIFO of fetch entries with push, pop, clear, count, and a head output.

Test Plan:
1. Reset, zero-wait memory returning addr^32'hA5A5_0000, decode always ready -> first fetch addr 0x3000_0000; entries pc 0x3000_0000, 0x3000_0004, 0x3000_0008 in order with matching inst.
2. idu_ready=0 for 10 cycles -> exactly 2 entries buffered; imem_req_valid=0 while fifo_count+outstanding==2; no loss or duplication when ready returns.
3. redirect_valid with redirect_pc=0x8000_0102 while a response is outstanding (3-cycle latency) -> FIFO cleared; stale response discarded; next request addr 0x8000_0100; first presented pc 0x8000_0100.
4. imem_req_ready held low 5 cycles, clear_pipeline pulsed at cycle 2 -> addr stays stable except for the allowed withdrawal; no entry presented before the new handshake.
5. imem_rsp_err=1 on the fetch of 0x3000_0004 -> entry presented with fetch_fault=1, inst=0x0000_0013; next entry pc 0x3000_0008 with fault=0.
6. pc=0xFFFF_FFFC via redirect -> the following fetch addr is 0x0000_0000; with FETCH_PERF_COUNTERS_EN defined, perf_drop_cnt increments exactly once per discarded response.
